fetch_unit: RTL and testbench

- Instruction-fetch stage of the 5-stage stall pipeline; sits directly upstream of the decode stage.
- Owns the fetch PC and issues one-at-a-time requests to instruction memory over a req/ready + valid handshake.
- Registers each returned instruction with its PC for decode.
- Holds its outputs under a stall, squashes on a branch/JAL redirect, and inserts NOP bubbles when no instruction is ready.

---
 rtl/fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_fetch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 5-stage stall pipeline.
// Owns the fetch PC, issues one request at a time to instruction memory
// (req/ready accept, later valid with data) and registers each returned
// instruction together with its PC for the decode stage. Outputs hold
// under stall, flush on redirect and show NOP bubbles when nothing is ready.
//
// Ports:
//   clock, reset            pipeline clock, asynchronous active-low reset
//   start                   level; leaves IDLE and begins fetching
//   stall                   hold PC/instruction/inst_valid
//   redirect, redirect_target  flush and refetch from target (word aligned)
//   imem_req, imem_addr     fetch request and registered fetch address
//   imem_ready              memory accepts the request this cycle
//   imem_valid, imem_rdata  returned instruction word
//   PC, instruction, inst_valid  registered instruction presented to decode
//   report                  per-cycle state print in simulation
module fetch_unit #(
  parameter int unsigned               CORE         = 0,
  parameter int unsigned               ADDRESS_BITS = 20,
  parameter logic [ADDRESS_BITS-1:0]   RESET_PC     = '0,
  parameter logic [31:0]               NOP          = 32'h00000013
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic [ADDRESS_BITS-1:0] redirect_target,
  output logic                    imem_req,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  input  logic                    imem_ready,
  input  logic                    imem_valid,
  input  logic [31:0]             imem_rdata,
  output logic [ADDRESS_BITS-1:0] PC,
  output logic [31:0]             instruction,
  output logic                    inst_valid,
  input  logic                    report
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t                  state, state_n;
  logic [ADDRESS_BITS-1:0] fetch_pc, fetch_pc_n;
  logic [ADDRESS_BITS-1:0] pc_q, pc_n;
  logic [ADDRESS_BITS-1:0] skid_pc, skid_pc_n;
  logic [31:0]             inst_q, inst_n;
  logic [31:0]             skid_inst, skid_inst_n;
  logic                    valid_q, valid_n;
  logic                    drop, drop_n;
  logic [31:0]             cycle;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      pc_q      <= RESET_PC;
      inst_q    <= NOP;
      valid_q   <= 1'b0;
      drop      <= 1'b0;
      skid_pc   <= RESET_PC;
      skid_inst <= NOP;
      cycle     <= '0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      pc_q      <= pc_n;
      inst_q    <= inst_n;
      valid_q   <= valid_n;
      drop      <= drop_n;
      skid_pc   <= skid_pc_n;
      skid_inst <= skid_inst_n;
      cycle     <= cycle + 32'd1;
    end
  end

  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    drop_n      = drop;
    skid_pc_n   = skid_pc;
    skid_inst_n = skid_inst;
    pc_n        = pc_q;
    inst_n      = inst_q;
    valid_n     = valid_q;

    // Without stall the output register shows a bubble unless a real
    // instruction is loaded below; PC keeps its last value.
    if (!stall) begin
      inst_n  = NOP;
      valid_n = 1'b0;
    end

    case (state)
      IDLE: if (start) state_n = REQ;
      REQ:  if (imem_ready) state_n = WAIT;
      WAIT: begin
        if (imem_valid) begin
          if (drop) begin
            drop_n  = 1'b0;
            state_n = REQ;
          end else if (!stall) begin
            pc_n       = fetch_pc;
            inst_n     = imem_rdata;
            valid_n    = 1'b1;
            fetch_pc_n = fetch_pc + ADDRESS_BITS'(4);
            state_n    = REQ;
          end else begin
            skid_pc_n   = fetch_pc;
            skid_inst_n = imem_rdata;
            fetch_pc_n  = fetch_pc + ADDRESS_BITS'(4);
            state_n     = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          pc_n    = skid_pc;
          inst_n  = skid_inst;
          valid_n = 1'b1;
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase

    // Redirect overrides everything above. The skid is only meaningful in
    // HOLD, so leaving HOLD is what discards it. A request already accepted
    // (or accepted this cycle) is marked for drop so its data is ignored.
    if (redirect) begin
      fetch_pc_n = {redirect_target[ADDRESS_BITS-1:2], 2'b00};
      pc_n       = pc_q;
      inst_n     = NOP;
      valid_n    = 1'b0;
      drop_n     = 1'b0;
      case (state)
        IDLE: state_n = IDLE;
        REQ: begin
          if (imem_ready) begin
            state_n = WAIT;
            drop_n  = 1'b1;
          end else begin
            state_n = REQ;
          end
        end
        WAIT: begin
          if (imem_valid) begin
            state_n = REQ;
          end else begin
            state_n = WAIT;
            drop_n  = 1'b1;
          end
        end
        HOLD:    state_n = REQ;
        default: state_n = IDLE;
      endcase
    end
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = fetch_pc;
  assign PC          = pc_q;
  assign instruction = inst_q;
  assign inst_valid  = valid_q;

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (report) begin
      $display("core %0d cycle %0d state %s fetch_pc %h PC %h instruction %h inst_valid %b stall %b redirect %b drop %b",
               CORE, cycle, state.name(), fetch_pc, pc_q, inst_q, valid_q, stall, redirect, drop);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory responder with per-request latency and a
// transaction-level reference model (expected next fetch address, queue of
// returned-but-not-yet-presented instructions, outstanding-request flag).
module tb_fetch_unit;

  localparam int unsigned      AB   = 20;
  localparam logic [AB-1:0]    RPC  = '0;
  localparam logic [31:0]      NOPW = 32'h00000013;

  logic          clock, reset, start, stall, redirect, report;
  logic [AB-1:0] redirect_target, imem_addr, PC;
  logic          imem_req, imem_ready, imem_valid, inst_valid;
  logic [31:0]   imem_rdata, instruction;

  fetch_unit #(
    .CORE(0), .ADDRESS_BITS(AB), .RESET_PC(RPC), .NOP(NOPW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .redirect(redirect), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .PC(PC),
    .instruction(instruction), .inst_valid(inst_valid), .report(report)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct { logic [AB-1:0] a; logic [31:0] d; } ent_t;

  ent_t          pend[$];
  logic [AB-1:0] acc_log[$];
  bit            started, m_busy, m_live, exp_v, fixed_en, spur_en;
  logic [AB-1:0] m_addr, exp_addr, exp_pc;
  logic [31:0]   exp_inst, fixed_word;
  int unsigned   cyc, m_due;

  function automatic logic [31:0] mem_word(input logic [AB-1:0] a);
    if (fixed_en) return fixed_word;
    return ({12'h000, a} * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < acc_log.size()) return 32'(acc_log[i]);
    return '1;
  endfunction

  task automatic model_reset();
    started  = 1'b0;
    m_busy   = 1'b0;
    m_live   = 1'b0;
    pend.delete();
    exp_addr = RPC;
    exp_pc   = RPC;
    exp_inst = NOPW;
    exp_v    = 1'b0;
  endtask

  // One clock cycle: entered just after a falling edge, drives inputs,
  // checks request outputs, lets the rising edge happen, updates the model
  // and checks the presented instruction, then returns at the next fall.
  task automatic step(input bit st, input bit rd, input logic [AB-1:0] tgt,
                      input bit rdy, input int unsigned lat);
    bit            deliver, accept, exp_req;
    logic [AB-1:0] addr_s;
    ent_t          e;
    stall           = st;
    redirect        = rd;
    redirect_target = tgt;
    imem_ready      = rdy;
    deliver = m_busy && (m_due == cyc);
    if (deliver) begin
      imem_valid = 1'b1;
      imem_rdata = mem_word(m_addr);
    end else begin
      imem_valid = spur_en && !m_busy && ($urandom_range(0, 3) == 0);
      imem_rdata = $urandom();
    end
    exp_req = started && !m_busy && (pend.size() == 0);
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", 32'(imem_addr), 32'(exp_addr));
    accept = imem_req && rdy;
    addr_s = imem_addr;

    @(posedge clock);
    #1;

    if (deliver) begin
      m_busy = 1'b0;
      if (m_live) begin
        e.a = m_addr;
        e.d = mem_word(m_addr);
        pend.push_back(e);
      end
    end
    if (rd) begin
      pend.delete();
      exp_inst = NOPW;
      exp_v    = 1'b0;
    end else if (!st) begin
      if (pend.size() != 0) begin
        e        = pend.pop_front();
        exp_pc   = e.a;
        exp_inst = e.d;
        exp_v    = 1'b1;
      end else begin
        exp_inst = NOPW;
        exp_v    = 1'b0;
      end
    end
    if (accept) begin
      m_busy   = 1'b1;
      m_live   = !rd;
      m_addr   = addr_s;
      m_due    = cyc + lat;
      exp_addr = exp_addr + AB'(4);
      acc_log.push_back(addr_s);
    end
    if (rd) begin
      exp_addr = {tgt[AB-1:2], 2'b00};
      m_live   = 1'b0;
    end
    if (start && !rd) started = 1'b1;

    check("PC", 32'(PC), 32'(exp_pc));
    check("instruction", instruction, exp_inst);
    check("inst_valid", 32'(inst_valid), 32'(exp_v));
    cyc++;
    @(negedge clock);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   32'(imem_req),   32'd0);
    check({tag, "_addr"},  32'(imem_addr),  32'(RPC));
    check({tag, "_pc"},    32'(PC),         32'(RPC));
    check({tag, "_inst"},  instruction,     NOPW);
    check({tag, "_valid"}, 32'(inst_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_target = '0; imem_ready = 1'b0; imem_valid = 1'b0;
    imem_rdata = '0; report = 1'b0;
    fixed_en = 1'b0; fixed_word = '0; spur_en = 1'b0; cyc = 0;
    model_reset();
    #1 reset = 1'b0;
    #1 check_reset_values("reset");
    @(negedge clock);
    reset = 1'b1;

    // Back-to-back fetch, 1-cycle memory, constant instruction.
    fixed_en   = 1'b1;
    fixed_word = 32'h00100093;
    start      = 1'b1;
    acc_log.delete();
    repeat (7) step(1'b0, 1'b0, '0, 1'b1, 1);
    check("seq_addr0", log_at(0), 32'h0);
    check("seq_addr1", log_at(1), 32'h4);
    check("seq_addr2", log_at(2), 32'h8);

    // Stall while waiting; returned word parks in the skid.
    fixed_word = 32'hDEADBEEF;
    step(1'b0, 1'b0, '0, 1'b1, 2);
    step(1'b1, 1'b0, '0, 1'b0, 1);
    step(1'b1, 1'b0, '0, 1'b0, 1);
    step(1'b1, 1'b0, '0, 1'b0, 1);
    step(1'b0, 1'b0, '0, 1'b0, 1);
    check("skid_inst", instruction, 32'hDEADBEEF);
    check("skid_valid", 32'(inst_valid), 32'd1);
    step(1'b0, 1'b0, '0, 1'b0, 1);

    // Redirect while waiting: late data dropped, refetch at aligned target.
    step(1'b0, 1'b0, '0, 1'b1, 3);
    step(1'b0, 1'b1, 20'h00123, 1'b0, 1);
    step(1'b0, 1'b0, '0, 1'b0, 1);
    step(1'b0, 1'b0, '0, 1'b0, 1);
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", 32'(imem_addr), 32'h00120);

    // Redirect during a stall with a valid instruction shown, to 0xFFFFC.
    step(1'b0, 1'b0, '0, 1'b1, 1);
    step(1'b0, 1'b0, '0, 1'b0, 1);
    step(1'b1, 1'b0, '0, 1'b0, 1);
    acc_log.delete();
    step(1'b1, 1'b1, 20'hFFFFC, 1'b0, 1);
    check("flush_valid", 32'(inst_valid), 32'd0);
    check("flush_inst", instruction, NOPW);
    repeat (4) step(1'b0, 1'b0, '0, 1'b1, 1);
    check("wrap_addr0", log_at(0), 32'hFFFFC);
    check("wrap_addr1", log_at(1), 32'h00000);

    // Asynchronous reset in the middle of a wait.
    step(1'b0, 1'b0, '0, 1'b1, 4);
    step(1'b0, 1'b0, '0, 1'b0, 1);
    #2 reset = 1'b0;
    #1 check_reset_values("async");
    model_reset();
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) step(1'b0, 1'b0, '0, 1'($urandom_range(0, 1)), 1);
    start = 1'b1;

    // Randomized traffic: stalls, redirects, back-pressure, latency, and
    // stray valids while no request is outstanding.
    fixed_en = 1'b0;
    spur_en  = 1'b1;
    report   = 1'b1;
    step(1'b0, 1'b0, '0, 1'b1, 1);
    report   = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 9) < 3),
           1'($urandom_range(0, 19) == 0),
           AB'($urandom()),
           1'($urandom_range(0, 9) < 6),
           $urandom_range(1, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
